// File: rtl/addsub_bist_pkg.sv
// -----------------------------------------------------------------------------
// addsub_bist_pkg
//   Shared constants and types for the 4-bit adder/subtractor BIST:
//   operand/result widths, vector count, error-counter saturation value,
//   FSM state encodings and the {M,A,B} vector layout.
// -----------------------------------------------------------------------------
package addsub_bist_pkg;

    // Operand and derived widths
    localparam int unsigned OP_W      = 4;
    localparam int unsigned RES_W     = OP_W + 1;
    localparam int unsigned IDX_W     = 2 * OP_W + 1;
    localparam int unsigned VEC_COUNT = 1 << IDX_W;
    localparam int unsigned SETTLE_W  = 4;

    // Last index of the sweep; the index never advances past it
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

    // Error counter width and saturation value
    localparam int unsigned      ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

    // FSM state encodings
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_APPLY = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Vector layout: index bit 8 is the mode, then A, then B
    typedef struct packed {
        logic            m;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } vec_t;

    // Saturating increment for the error counter
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] r;
        r = (v == ERR_MAX) ? v : v + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/addsub_ref_model.sv
// -----------------------------------------------------------------------------
// addsub_ref_model
//   Combinational golden model of the 4-bit adder/subtractor under test.
//   Ports:
//     m_i    - mode (0 add, 1 subtract)
//     a_i    - operand A
//     b_i    - operand B
//     exp_o  - expected {cout, s}; for subtract cout=1 means no borrow (A>=B)
// -----------------------------------------------------------------------------
module addsub_ref_model
    import addsub_bist_pkg::*;
(
    input  logic             m_i,
    input  logic [OP_W-1:0]  a_i,
    input  logic [OP_W-1:0]  b_i,
    output logic [RES_W-1:0] exp_o
);

    always_comb begin
        exp_o = '0;
        if (m_i) begin
            // Two's-complement subtract: A + ~B + 1, carry out is "no borrow"
            exp_o = {1'b0, a_i} + {1'b0, ~b_i} + RES_W'(1);
        end else begin
            exp_o = {1'b0, a_i} + {1'b0, b_i};
        end
    end

endmodule

// File: rtl/addsub_bist.sv
// -----------------------------------------------------------------------------
// addsub_bist
//   Exhaustive sweep BIST for an external 4-bit adder/subtractor. Drives all
//   512 {M,A,B} vectors in ascending order, holds each for SETTLE_CYCLES,
//   then compares the returned {cout,s} against addsub_ref_model.
//   Parameters:
//     SETTLE_CYCLES - cycles each vector is held before sampling (1..15)
//     STOP_ON_FAIL  - 1 ends the sweep at the first mismatching vector
//   Ports:
//     clk, rst_n        - clock, asynchronous active-low reset
//     start             - single-cycle sweep request (ignored while busy)
//     drv_a/drv_b/drv_m - vector driven to the adder/subtractor
//     dut_s/dut_cout    - response from the adder/subtractor
//     busy, done, pass  - sweep status; pass valid while done=1
//     err_count         - mismatch count, saturating at 255
//     fail_vec          - {M,A,B} of first mismatch, qualified by fail_valid
// -----------------------------------------------------------------------------
module addsub_bist
    import addsub_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          STOP_ON_FAIL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [OP_W-1:0]  drv_a,
    output logic [OP_W-1:0]  drv_b,
    output logic             drv_m,
    input  logic [OP_W-1:0]  dut_s,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] fail_vec,
    output logic             fail_valid
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              state_q,  state_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [ERR_W-1:0]    err_q,    err_d;
    logic [IDX_W-1:0]    fvec_q,   fvec_d;
    logic                fvalid_q, fvalid_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                pass_q,   pass_d;

    vec_t             cur_vec;
    logic [RES_W-1:0] exp_res;
    logic             mismatch;
    logic             start_ok;

    assign cur_vec = vec_t'(idx_q);

    addsub_ref_model u_ref (
        .m_i   (cur_vec.m),
        .a_i   (cur_vec.a),
        .b_i   (cur_vec.b),
        .exp_o (exp_res)
    );

    assign mismatch = ({dut_cout, dut_s} != exp_res);
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // busy/done/pass are registered from the current state, so they follow
    // the state by one cycle; a start accepted in DONE clears done/pass at
    // once so no stale result is visible during the new sweep.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        fvalid_d = fvalid_q;
        busy_d   = (state_q == ST_APPLY) || (state_q == ST_CHECK);
        done_d   = (state_q == ST_DONE);
        pass_d   = (state_q == ST_DONE) && (err_q == '0);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d  = ST_APPLY;
                    idx_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    fvec_d   = '0;
                    fvalid_d = 1'b0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                end
            end

            ST_APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_CHECK;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            ST_CHECK: begin
                if (mismatch) begin
                    err_d = sat_inc(err_q);
                    if (!fvalid_q) begin
                        fvec_d   = idx_q;
                        fvalid_d = 1'b1;
                    end
                end
                if ((idx_q == LAST_IDX) || (mismatch && STOP_ON_FAIL)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_APPLY;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fvec_q   <= '0;
            fvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fvec_q   <= fvec_d;
            fvalid_q <= fvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign drv_m      = cur_vec.m;
    assign drv_a      = cur_vec.a;
    assign drv_b      = cur_vec.b;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_vec   = fvec_q;
    assign fail_valid = fvalid_q;

endmodule

// File: tb/tb_addsub_bist.sv
module tb_addsub_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n;
    logic [2:0] start;
    logic [2:0] busy, done, pass, fvalid, drv_m;
    logic [3:0] drv_a [3];
    logic [3:0] drv_b [3];
    logic [7:0] err   [3];
    logic [8:0] fvec  [3];
    int         fault [3];

    logic [4:0] r0, r1, r2, d1, d2;

    int n_tests = 0;
    int n_fail  = 0;

    // Emulated external adder/subtractor with optional planted faults:
    // 1 = s[0] stuck at 0, 2 = wrong s only for M=0,A=3,B=1
    function automatic logic [4:0] ext_addsub(input logic m, input logic [3:0] a,
                                              input logic [3:0] b, input int f);
        logic [4:0] r;
        if (m) r = 5'({1'b0, a} - {1'b0, b}) ^ 5'h10;
        else   r = {1'b0, a} + {1'b0, b};
        if (f == 1) r[0] = 1'b0;
        if (f == 2 && !m && a == 4'd3 && b == 4'd1) r[3] = ~r[3];
        return r;
    endfunction

    always_comb r0 = ext_addsub(drv_m[0], drv_a[0], drv_b[0], fault[0]);
    always_comb r1 = ext_addsub(drv_m[1], drv_a[1], drv_b[1], fault[1]);
    always_ff @(posedge clk) begin
        d1 <= ext_addsub(drv_m[2], drv_a[2], drv_b[2], fault[2]);
        d2 <= d1;
    end
    assign r2 = d2;

    addsub_bist #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]),
        .drv_a(drv_a[0]), .drv_b(drv_b[0]), .drv_m(drv_m[0]),
        .dut_s(r0[3:0]), .dut_cout(r0[4]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err[0]), .fail_vec(fvec[0]), .fail_valid(fvalid[0]));

    addsub_bist #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]),
        .drv_a(drv_a[1]), .drv_b(drv_b[1]), .drv_m(drv_m[1]),
        .dut_s(r1[3:0]), .dut_cout(r1[4]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err[1]), .fail_vec(fvec[1]), .fail_valid(fvalid[1]));

    addsub_bist #(.SETTLE_CYCLES(3), .STOP_ON_FAIL(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n[2]), .start(start[2]),
        .drv_a(drv_a[2]), .drv_b(drv_b[2]), .drv_m(drv_m[2]),
        .dut_s(r2[3:0]), .dut_cout(r2[4]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(err[2]), .fail_vec(fvec[2]), .fail_valid(fvalid[2]));

    typedef struct {
        int inst;
        int flt;
        int exp_cyc;
        int exp_err;
        int exp_pass;
        int exp_fv;
        int exp_fvec;
        int exp_last;
    } vec_rec_t;

    vec_rec_t tbl [8];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int idx_of(input int i);
        return int'({drv_m[i], drv_a[i], drv_b[i]});
    endfunction

    // Pulses start, then counts rising edges after the start edge until done.
    // Optionally re-pulses start when the driven index reaches `repulse`.
    task automatic sweep(input int i, input int repulse, output int cyc, output int busy1);
        bit rp_done;
        rp_done = 1'b0;
        busy1   = 0;
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        while (cyc < 5000) begin
            @(negedge clk);
            if (repulse >= 0 && !rp_done && idx_of(i) == repulse) begin
                start[i] = 1'b1;
                rp_done  = 1'b1;
            end else begin
                start[i] = 1'b0;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) busy1 = int'(busy[i]);
            if (done[i]) break;
        end
        start[i] = 1'b0;
    endtask

    task automatic check_result(input string tag, input int i, input int cyc, input int b1,
                                input int e_cyc, input int e_err, input int e_pass,
                                input int e_fv, input int e_fvec, input int e_last);
        check({tag, " done_cycle"}, cyc, e_cyc);
        check({tag, " busy_after_start"}, b1, 1);
        check({tag, " busy_in_done"}, int'(busy[i]), 0);
        check({tag, " err_count"}, int'(err[i]), e_err);
        check({tag, " pass"}, int'(pass[i]), e_pass);
        check({tag, " fail_valid"}, int'(fvalid[i]), e_fv);
        check({tag, " fail_vec"}, int'(fvec[i]), e_fvec);
        check({tag, " last_vec"}, idx_of(i), e_last);
    endtask

    initial begin
        int cyc, b1, guard;

        //        inst flt  cyc  err pass fv fvec last
        tbl[0] = '{0, 0, 1025,   0, 1, 0,  0, 511};
        tbl[1] = '{0, 1, 1025, 255, 0, 1,  1, 511};
        tbl[2] = '{0, 2, 1025,   1, 0, 1, 49, 511};
        tbl[3] = '{1, 2,  101,   1, 0, 1, 49,  49};
        tbl[4] = '{1, 1,    5,   1, 0, 1,  1,   1};
        tbl[5] = '{1, 0, 1025,   0, 1, 0,  0, 511};
        tbl[6] = '{2, 0, 2049,   0, 1, 0,  0, 511};
        tbl[7] = '{2, 1, 2049, 255, 0, 1,  1, 511};

        rst_n = '0;
        start = '0;
        for (int i = 0; i < 3; i++) fault[i] = 0;
        #23;
        rst_n = '1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   int'(busy[0]),   0);
        check("reset done",   int'(done[0]),   0);
        check("reset pass",   int'(pass[0]),   0);
        check("reset err",    int'(err[0]),    0);
        check("reset fvalid", int'(fvalid[0]), 0);
        check("reset drv",    idx_of(0),       0);

        for (int k = 0; k < 8; k++) begin
            fault[tbl[k].inst] = tbl[k].flt;
            sweep(tbl[k].inst, -1, cyc, b1);
            check_result($sformatf("vec%0d", k), tbl[k].inst, cyc, b1,
                         tbl[k].exp_cyc, tbl[k].exp_err, tbl[k].exp_pass,
                         tbl[k].exp_fv, tbl[k].exp_fvec, tbl[k].exp_last);
        end

        // start re-pulsed mid-sweep is ignored; sweep keeps its schedule
        fault[0] = 0;
        sweep(0, 20, cyc, b1);
        check_result("repulse", 0, cyc, b1, 1025, 0, 1, 0, 0, 511);

        // asynchronous reset in the middle of a failing sweep
        fault[0] = 1;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        guard = 0;
        while (idx_of(0) != 100 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("reach index 100", idx_of(0), 100);
        check("err before reset nonzero", int'(err[0] != 0), 1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check("async rst busy",   int'(busy[0]),   0);
        check("async rst done",   int'(done[0]),   0);
        check("async rst pass",   int'(pass[0]),   0);
        check("async rst err",    int'(err[0]),    0);
        check("async rst fvalid", int'(fvalid[0]), 0);
        check("async rst fvec",   int'(fvec[0]),   0);
        check("async rst drv",    idx_of(0),       0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle after rst busy", int'(busy[0]), 0);
        check("idle after rst done", int'(done[0]), 0);
        check("idle after rst drv",  idx_of(0),     0);
        fault[0] = 0;
        sweep(0, -1, cyc, b1);
        check_result("post_reset", 0, cyc, b1, 1025, 0, 1, 0, 0, 511);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
